// File: rtl/i_o_output_controller.sv
// ============================================================================
// i_o_output_controller : UART-style transmitter, 8 data bits MSB-first,
// one-byte holding register. Optional even parity via I_O_OUTPUT_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module i_o_output_controller #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE,
  parameter int STOP_BITS  = 1,
  parameter int SIZE       = $clog2(BIT_PERIOD + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_output_trigger,
  input  logic [7:0] io_output_value,
  output logic       io_output_ready,
  output logic       io_output_busy,
  output logic       RXD
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [SIZE-1:0] C_RELOAD    = SIZE'(BIT_PERIOD - 1);
  localparam logic [2:0]      C_LAST_STOP = 3'(STOP_BITS - 1);

  state_t           state_q, state_d;
  logic [SIZE-1:0]  timer_q, timer_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             kick_q, kick_d;
  logic             rxd_q, rxd_d;
  logic             parity_q, parity_d;
  logic             accept;
  logic             drain;
  logic             bit_end;

  assign accept  = io_output_trigger && !hold_full_q;
  assign bit_end = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    drain   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 3'd0;
        // kick_q delays the first drain by one cycle so the start bit lands two edges after accept
        if (hold_full_q && kick_q) begin
          drain   = 1'b1;
          state_d = S_START;
          timer_d = C_RELOAD;
          shift_d = hold_q;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          timer_d = C_RELOAD;
          cnt_d   = 3'd0;
        end else begin
          timer_d = timer_q - SIZE'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          timer_d = C_RELOAD;
          if (cnt_q == 3'd7) begin
            cnt_d   = 3'd0;
`ifdef I_O_OUTPUT_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - SIZE'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          timer_d = C_RELOAD;
          cnt_d   = 3'd0;
        end else begin
          timer_d = timer_q - SIZE'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (cnt_q == C_LAST_STOP) begin
            cnt_d = 3'd0;
            if (hold_full_q) begin
              drain   = 1'b1;
              state_d = S_START;
              timer_d = C_RELOAD;
              shift_d = hold_q;
            end else begin
              state_d = S_IDLE;
              timer_d = '0;
            end
          end else begin
            cnt_d   = cnt_q + 3'd1;
            timer_d = C_RELOAD;
          end
        end else begin
          timer_d = timer_q - SIZE'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        cnt_d   = 3'd0;
      end
    endcase

    hold_full_d = drain ? 1'b0 : (accept ? 1'b1 : hold_full_q);
    hold_d      = accept ? io_output_value : hold_q;
    kick_d      = (state_q == S_IDLE) && hold_full_q && !drain;
`ifdef I_O_OUTPUT_PARITY_EN
    parity_d    = drain ? ^hold_q : parity_q;
`else
    parity_d    = 1'b0;
`endif

    case (state_d)
      S_START:  rxd_d = 1'b0;
      S_DATA:   rxd_d = shift_d[7];
      S_PARITY: rxd_d = parity_d;
      default:  rxd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      cnt_q       <= 3'd0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      kick_q      <= 1'b0;
      rxd_q       <= 1'b1;
      parity_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      kick_q      <= kick_d;
      rxd_q       <= rxd_d;
      parity_q    <= parity_d;
    end
  end

  assign io_output_ready = !hold_full_q;
  assign io_output_busy  = (state_q != S_IDLE) || hold_full_q;
  assign RXD             = rxd_q;

endmodule

`default_nettype wire

// File: tb/tb_i_o_output_controller.sv
// ============================================================================
// tb_i_o_output_controller : directed bench for the UART transmitter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_i_o_output_controller;

  localparam int BP = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trig, trig2;
  logic [7:0] val, val2;
  logic       ready, busy, rxd;
  logic       ready2, busy2, rxd2;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  i_o_output_controller #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_output_trigger(trig), .io_output_value(val),
    .io_output_ready(ready), .io_output_busy(busy), .RXD(rxd)
  );

  i_o_output_controller #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .io_output_trigger(trig2), .io_output_value(val2),
    .io_output_ready(ready2), .io_output_busy(busy2), .RXD(rxd2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    val  = d;
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  // Walks one frame from the first start-bit cycle; after the first tick drives new trigger/value.
  task automatic check_frame(input logic [7:0] data, input int stops, input bit sel,
                             input logic nt, input logic [7:0] nv);
    int   b;
    logic e;
    for (int c = 0; c < (9 + stops) * BP; c++) begin
      b = c / BP;
      if (b == 0)      e = 1'b0;
      else if (b <= 8) e = data[8 - b];
      else             e = 1'b1;
      chk($sformatf("rxd %0h c%0d", data, c), {31'd0, sel ? rxd2 : rxd}, {31'd0, e});
      chk($sformatf("busy %0h c%0d", data, c), {31'd0, sel ? busy2 : busy}, 32'd1);
      tick();
      if (c == 0) begin
        trig = nt;
        val  = nv;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; trig = 1'b0; val = 8'h00; trig2 = 1'b0; val2 = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset rxd", {31'd0, rxd}, 32'd1);
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rxd2", {31'd0, rxd2}, 32'd1);
    chk("reset ready2", {31'd0, ready2}, 32'd1);

    // Single frame 0xA5
    send(8'hA5);
    chk("a5 ready after accept", {31'd0, ready}, 32'd0);
    chk("a5 busy after accept", {31'd0, busy}, 32'd1);
    tick();
    chk("a5 rxd k+1", {31'd0, rxd}, 32'd1);
    chk("a5 ready k+1", {31'd0, ready}, 32'd0);
    tick();
    chk("a5 ready k+2", {31'd0, ready}, 32'd1);
    check_frame(8'hA5, 1, 1'b0, 1'b0, 8'h00);
    chk("a5 busy end", {31'd0, busy}, 32'd0);
    chk("a5 rxd end", {31'd0, rxd}, 32'd1);

    // Back-to-back 0x3C then 0xFF
    repeat (3) tick();
    send(8'h3C);
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    chk("3c ready latency", n, 32'd2);
    trig = 1'b1;
    val  = 8'hFF;
    check_frame(8'h3C, 1, 1'b0, 1'b0, 8'h00);
    check_frame(8'hFF, 1, 1'b0, 1'b0, 8'h00);
    chk("ff busy end", {31'd0, busy}, 32'd0);

    // Trigger held high through ready=0 periods
    repeat (3) tick();
    val  = 8'h12;
    trig = 1'b1;
    tick();
    val = 8'h99;
    tick();
    chk("hold ready k+1", {31'd0, ready}, 32'd0);
    tick();
    check_frame(8'h12, 1, 1'b0, 1'b1, 8'h55);
    chk("hold ready after frame1", {31'd0, ready}, 32'd1);
    check_frame(8'h99, 1, 1'b0, 1'b0, 8'h00);
    check_frame(8'h55, 1, 1'b0, 1'b0, 8'h00);
    chk("hold busy end", {31'd0, busy}, 32'd0);

    // Reset in the middle of data bit 4 of 0x00, with a byte also held
    repeat (3) tick();
    send(8'h00);
    tick();
    tick();
    trig = 1'b1;
    val  = 8'h5A;
    tick();
    trig = 1'b0;
    repeat (54) tick();
    chk("pre-reset rxd", {31'd0, rxd}, 32'd0);
    chk("pre-reset ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async reset rxd", {31'd0, rxd}, 32'd1);
    chk("async reset ready", {31'd0, ready}, 32'd1);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 130; c++) begin
      tick();
      chk($sformatf("post-reset rxd c%0d", c), {31'd0, rxd}, 32'd1);
      chk($sformatf("post-reset busy c%0d", c), {31'd0, busy}, 32'd0);
    end

    // Two stop bits, 0x81
    val2  = 8'h81;
    trig2 = 1'b1;
    tick();
    trig2 = 1'b0;
    tick();
    tick();
    check_frame(8'h81, 2, 1'b1, 1'b0, 8'h00);
    chk("stop2 busy end", {31'd0, busy2}, 32'd0);
    chk("stop2 rxd end", {31'd0, rxd2}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i_o_output_controller.md
Name: i_o_output_controller

Overview:
- UART-style serial transmitter; the transmit-side counterpart of the I/O input controller.
- Accepts bytes through a valid/ready strobe and drives one line, RXD: start bit, 8 data bits MSB-first (the same bit order the input controller reassembles), then stop bit(s).
- A one-byte holding register lets software queue the next byte while the current frame is on the wire, giving back-to-back frames with no idle gap.

Parameters:
- CLOCK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- BIT_PERIOD, CLOCK_FREQ / BAUD_RATE, clock cycles per bit (integer division); must be >= 2.
- STOP_BITS, 1, number of stop bits (1 or 2).
- SIZE, $clog2(BIT_PERIOD + 1), bit-timer width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- io_output_trigger  input  1  byte-valid strobe.
- io_output_value  input  8  byte to send; sampled only when accepted.
- io_output_ready  output  1  high when the holding register is empty.
- io_output_busy  output  1  high while a frame is being shifted out or the holding register is full.
- RXD  output  1  serial line; idle high.

Behaviour:
- Reset values (async on rst_n low, all registers): RXD=1, io_output_ready=1, io_output_busy=0, holding empty, state IDLE, bit timer=0, bit counter=0.
- Accept rule: the byte is accepted on a rising edge where io_output_trigger && io_output_ready. The trigger is ignored when ready=0, with no effect on any state. Holding a trigger high issues one byte per edge on which ready is high.
- Holding register: loaded on accept; ready drops on the next edge. It is emptied when the FSM moves it into the shift register, and ready rises on that same edge.
- FSM states and transitions:
  - IDLE: RXD=1. If holding is full, move holding into the shift register and go to START.
  - START: RXD=0 for exactly BIT_PERIOD cycles, then DATA.
  - DATA: RXD = shift[7] for BIT_PERIOD cycles, then shift left by 1. After 8 bits go to STOP, or to PARITY when that feature is enabled.
  - STOP: RXD=1 for STOP_BITS*BIT_PERIOD cycles. At the end, if holding is full, load it and go straight to START (zero gap); otherwise go to IDLE.
- Latency: byte accepted on edge k with the FSM in IDLE gives holding loaded at k, START entered and RXD=0 registered at edge k+2. Full frame length is (9+STOP_BITS)*BIT_PERIOD cycles.
- Bit timer:
  - Reloaded with BIT_PERIOD-1 on every state or bit change; the bit ends when it reaches 0.
  - Every bit lasts exactly BIT_PERIOD cycles, with no cumulative drift and no wrap.
- Simultaneous events:
  - Accept on the same edge that the FSM drains holding is not possible, because ready=0 while holding is full.
  - Accept on the edge after the drain is legal and fills the now-empty holding register.
- io_output_busy = (state != IDLE) || holding full; it is combinational from registers.
- Reset mid-frame: RXD returns to 1 immediately (async), and both the partial frame and the held byte are discarded.
- RXD is driven directly from a flop, so it is glitch-free.

Optional Feature:
- Macro: I_O_OUTPUT_PARITY_EN.
- When defined:
  - A PARITY state follows DATA and drives even parity (XOR of the 8 data bits) for BIT_PERIOD cycles.
  - Frame length becomes (10+STOP_BITS)*BIT_PERIOD cycles.
- When undefined:
  - There is no PARITY state, and DATA goes directly to STOP.
  - This is the default, and it is required when the peer is the existing input controller, which has no parity support.

Test Plan:
- CLOCK_FREQ=1000, BAUD_RATE=100 (BIT_PERIOD=10); reset, then send 0xA5 -> RXD low for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles; ready back high 2 cycles after accept; busy falls exactly 100 cycles after the start bit begins.
- Send 0x3C, then 0xFF as soon as ready rises -> second start bit begins on the cycle immediately after the first stop bit ends (no idle gap); line data decodes to 0x3C, 0xFF.
- Hold trigger high with ready=0 during a frame -> no extra byte is accepted and the frame is unchanged; the byte is accepted only on the first edge where ready=1.
- Assert rst_n=0 in the middle of data bit 4 of 0x00 -> RXD=1 within the same cycle; after release, ready=1, busy=0, and no residual frame is emitted.
- STOP_BITS=2, send 0x81 -> stop level lasts 20 cycles; total frame is 110 cycles.
- I_O_OUTPUT_PARITY_EN defined: 0x07 -> parity bit=1; 0x03 -> parity bit=0; each frame is 110 cycles long. Loopback of the default build into the input controller -> its received value equals the sent value for 0x00, 0x55, 0xAA, 0xFF.
